// File: rtl/s2f_gray_count_rx.sv
// Receive side of a Gray-coded counter crossing: synchronises the bus, converts
// it to binary, reports per-sample increments and flags illegal steps.
module s2f_gray_count_rx #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_STEP    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] delta,
  output logic             upd,
  output logic             step_err,
  output logic [1:0]       state
);

  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'b00,
    ST_TRACK   = 2'b01,
    ST_ERROR   = 2'b10
  } state_e;

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  bin_c;
  logic [WIDTH-1:0]  diff_c;

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  delta_q, delta_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;

  // Synchroniser chain for the asynchronous Gray bus
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin_c[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
    diff_c = bin_c - count_q;
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    count_d = count_q;
    delta_d = '0;
    upd_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_ACQUIRE: begin
        // Wait until the chain holds real samples, then take a silent baseline
        if (fill_q == FILL_W'(SYNC_STAGES)) begin
          count_d = bin_c;
          fill_d  = '0;
          state_d = ST_TRACK;
        end else begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
      ST_TRACK: begin
        if (diff_c != '0) begin
          count_d = bin_c;
          delta_d = diff_c;
          upd_d   = 1'b1;
          if (diff_c > WIDTH'(MAX_STEP)) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        // Keep following the count; only clr_err leaves this state
        if (diff_c != '0) begin
          count_d = bin_c;
          delta_d = diff_c;
          upd_d   = 1'b1;
        end
        if (clr_err) begin
          err_d   = 1'b0;
          fill_d  = '0;
          state_d = ST_ACQUIRE;
        end
      end
      default: begin
        fill_d  = '0;
        state_d = ST_ACQUIRE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_ACQUIRE;
      fill_q  <= '0;
      count_q <= '0;
      delta_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      delta_q <= delta_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign count_out = count_q;
  assign delta     = delta_q;
  assign upd       = upd_q;
  assign step_err  = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_s2f_gray_count_rx.sv
// Scoreboard bench for s2f_gray_count_rx with directed Gray-count sequences.
module tb_s2f_gray_count_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] count_out;
  logic [3:0] delta;
  logic       upd;
  logic       step_err;
  logic [1:0] state;

  typedef struct {
    int count;
    int dlt;
    int err;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  s2f_gray_count_rx #(.WIDTH(4), .SYNC_STAGES(2), .MAX_STEP(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .gray_in   (gray_in),
    .clr_err   (clr_err),
    .count_out (count_out),
    .delta     (delta),
    .upd       (upd),
    .step_err  (step_err),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every upd pulse must match the oldest expected update
  always @(negedge clk) begin
    exp_t e;
    if (upd === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_upd", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("upd_count", int'(count_out), e.count);
        chk("upd_delta", int'(delta), e.dlt);
        chk("upd_step_err", int'(step_err), e.err);
        chk("upd_latency_cycle", cyc, e.cyc);
      end
    end else if (reset_n !== 1'bx) begin
      chk("idle_delta_zero", int'(delta), 0);
    end
  end

  // Drive a new binary count (as Gray) at a negedge and expect its update 3 edges later
  task automatic step(input int b, input int d, input int e);
    exp_t x;
    gray_in = to_gray(4'(b));
    x.count = b; x.dlt = d; x.err = e; x.cyc = cyc + 3;
    exp_q.push_back(x);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int budget;
    reset_n = 1'b0;
    clr_err = 1'b0;
    gray_in = 4'b0110;

    // 1: reset and acquisition of bin 4
    repeat (2) @(negedge clk);
    chk("rst_count", int'(count_out), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_step_err", int'(step_err), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("acq_count", int'(count_out), 4);
    chk("acq_state", int'(state), 1);

    // 2: single increment with latency check
    step(5, 1, 0);

    // 3: steps of 2 including wrap 15 -> 1
    step(7, 2, 0);
    step(9, 2, 0);
    step(11, 2, 0);
    step(13, 2, 0);
    step(15, 2, 0);
    step(1, 2, 0);
    chk("wrap_step_err", int'(step_err), 0);

    // 4: illegal jump 5 -> 12, then tracking continues in ERROR
    step(4, 3, 0);
    step(5, 1, 0);
    step(12, 7, 1);
    chk("err_state", int'(state), 2);
    chk("err_sticky", int'(step_err), 1);
    step(13, 1, 1);
    chk("err_still_state", int'(state), 2);

    // 5: clear error and re-acquire silently at 13
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_step_err", int'(step_err), 0);
    chk("clr_state", int'(state), 0);
    repeat (3) @(negedge clk);
    chk("reacq_state", int'(state), 1);
    chk("reacq_count", int'(count_out), 13);

    // clr_err while tracking has no effect
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_in_track_state", int'(state), 1);

    // 6: walk to 9 then reset mid-track
    step(15, 2, 0);
    step(1, 2, 0);
    step(3, 2, 0);
    step(5, 2, 0);
    step(7, 2, 0);
    step(9, 2, 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_count", int'(count_out), 0);
    chk("midrst_delta", int'(delta), 0);
    chk("midrst_upd", int'(upd), 0);
    chk("midrst_step_err", int'(step_err), 0);
    chk("midrst_state", int'(state), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_count", int'(count_out), 9);
    chk("post_rst_state", int'(state), 1);
    chk("post_rst_step_err", int'(step_err), 0);

    // Drain: every expected update must have been seen
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("missing_upd", -1, e.count);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
